// File: rtl/dtc_vote_pkg.sv
// Shared types and constants for the decision-tree vote accumulator.
//   CLASS_W     : width of a class code produced by the tree
//   NUM_CLASSES : number of histogram bins (2**CLASS_W)
//   state_e     : accumulator FSM states
//   class_t     : class code type
package dtc_vote_pkg;

  localparam int unsigned CLASS_W     = 3;
  localparam int unsigned NUM_CLASSES = 2 ** CLASS_W;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef logic [CLASS_W-1:0] class_t;

endpackage

// File: rtl/dtc_vote_accum_if.sv
// Handshake bundle between the tree output, the vote accumulator and the result consumer.
//   in_valid/in_ready/in_class    : prediction stream into the accumulator
//   out_valid/out_ready           : result handshake
//   out_class/out_votes/out_total : winning class, its votes, samples in the window
//   busy                          : accumulator is scanning or holding a result
//   flush                         : early window end (only when DTC_VOTE_FLUSH_EN is defined)
// slave modport is the accumulator side, master modport is the environment side.
interface dtc_vote_accum_if #(
  parameter int unsigned CNT_W = 5
);
  import dtc_vote_pkg::*;

  logic             in_valid;
  logic             in_ready;
  class_t           in_class;
  logic             out_valid;
  logic             out_ready;
  class_t           out_class;
  logic [CNT_W-1:0] out_votes;
  logic [CNT_W-1:0] out_total;
  logic             busy;

`ifdef DTC_VOTE_FLUSH_EN
  logic             flush;

  modport slave (
    input  in_valid, in_class, out_ready, flush,
    output in_ready, out_valid, out_class, out_votes, out_total, busy
  );
  modport master (
    output in_valid, in_class, out_ready, flush,
    input  in_ready, out_valid, out_class, out_votes, out_total, busy
  );
`else
  modport slave (
    input  in_valid, in_class, out_ready,
    output in_ready, out_valid, out_class, out_votes, out_total, busy
  );
  modport master (
    output in_valid, in_class, out_ready,
    input  in_ready, out_valid, out_class, out_votes, out_total, busy
  );
`endif

endinterface

// File: rtl/dtc_vote_hist.sv
// Per-class vote counter bank with a single read port for the argmax scan.
//   clk, rst   : clock and synchronous active-high reset
//   inc_i      : increment the bin selected by idx_i
//   idx_i      : bin to increment
//   clr_i      : clear every bin (window handed off)
//   rd_idx_i   : bin to read
//   rd_cnt_o   : count of bin rd_idx_i
module dtc_vote_hist
  import dtc_vote_pkg::*;
#(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  class_t           idx_i,
  input  logic             clr_i,
  input  class_t           rd_idx_i,
  output logic [CNT_W-1:0] rd_cnt_o
);

  logic [CNT_W-1:0] cnt_q [NUM_CLASSES];

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        cnt_q[k] <= '0;
      end
    end else if (inc_i) begin
      // Bounded by the window length, so no saturation is needed.
      cnt_q[idx_i] <= cnt_q[idx_i] + 1'b1;
    end
  end

  assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/dtc_vote_accum.sv
// Accumulates class predictions over a window and reports the majority class.
//   clk, rst : clock and synchronous active-high reset
//   bus      : dtc_vote_accum_if slave side (prediction in, result out, busy, optional flush)
// Flow: ACCUM counts WINDOW accepts, SCAN walks every bin once keeping the strictly larger
// count (ties keep the lower class), HOLD presents the result until it is taken.
// Optional macro DTC_VOTE_FLUSH_EN adds bus.flush to end a non-empty window early.
module dtc_vote_accum
  import dtc_vote_pkg::*;
#(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic            clk,
  input  logic            rst,
  dtc_vote_accum_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] best_votes_q, best_votes_d;
  class_t           best_class_q, best_class_d;
  class_t           scan_idx_q, scan_idx_d;
  logic             out_valid_q, out_valid_d;
  class_t           out_class_q, out_class_d;
  logic [CNT_W-1:0] out_votes_q, out_votes_d;
  logic [CNT_W-1:0] out_total_q, out_total_d;

  logic             accept;
  logic             hist_clr;
  logic             win_end;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W:0]   total_inc;

  assign accept    = bus.in_valid && (state_q == ACCUM);
  assign total_inc = {1'b0, total_q} + (CNT_W + 1)'(1);

`ifdef DTC_VOTE_FLUSH_EN
  // A flush closes the window only if it would contain at least one sample.
  assign win_end = (accept && (total_inc == (CNT_W + 1)'(WINDOW))) ||
                   (bus.flush && (accept || (total_q != '0)));
`else
  assign win_end = accept && (total_inc == (CNT_W + 1)'(WINDOW));
`endif

  dtc_vote_hist #(
    .CNT_W(CNT_W)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (accept),
    .idx_i   (bus.in_class),
    .clr_i   (hist_clr),
    .rd_idx_i(scan_idx_q),
    .rd_cnt_o(rd_cnt)
  );

  always_comb begin
    state_d      = state_q;
    total_d      = total_q;
    best_votes_d = best_votes_q;
    best_class_d = best_class_q;
    scan_idx_d   = scan_idx_q;
    out_valid_d  = out_valid_q;
    out_class_d  = out_class_q;
    out_votes_d  = out_votes_q;
    out_total_d  = out_total_q;
    hist_clr     = 1'b0;

    unique case (state_q)
      ACCUM: begin
        total_d = total_q + CNT_W'(accept);
        if (win_end) begin
          state_d      = SCAN;
          scan_idx_d   = '0;
          best_class_d = '0;
          best_votes_d = '0;
        end
      end
      SCAN: begin
        if (rd_cnt > best_votes_q) begin
          best_votes_d = rd_cnt;
          best_class_d = scan_idx_q;
        end
        scan_idx_d = scan_idx_q + 1'b1;
        if (scan_idx_q == class_t'(NUM_CLASSES - 1)) begin
          // Last bin's comparison is folded straight into the output registers.
          state_d     = HOLD;
          out_valid_d = 1'b1;
          out_class_d = best_class_d;
          out_votes_d = best_votes_d;
          out_total_d = total_q;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d      = ACCUM;
          out_valid_d  = 1'b0;
          hist_clr     = 1'b1;
          total_d      = '0;
          best_votes_d = '0;
          best_class_d = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      total_q      <= '0;
      best_votes_q <= '0;
      best_class_q <= '0;
      scan_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_votes_q  <= '0;
      out_total_q  <= '0;
    end else begin
      state_q      <= state_d;
      total_q      <= total_d;
      best_votes_q <= best_votes_d;
      best_class_q <= best_class_d;
      scan_idx_q   <= scan_idx_d;
      out_valid_q  <= out_valid_d;
      out_class_q  <= out_class_d;
      out_votes_q  <= out_votes_d;
      out_total_q  <= out_total_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.busy      = (state_q != ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_votes = out_votes_q;
  assign bus.out_total = out_total_q;

endmodule
